// File: rtl/pulse_interval_meter.sv
// rtl/pulse_interval_meter.sv - measures the period of a GPIO pulse in prescaled ticks, reported as two BCD digits
module pulse_interval_meter #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter logic [7:0]  MAX_BCD  = 8'h99
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pulse_in,
  input  logic       clear,
  output logic [7:0] count_bcd,
  output logic       valid,
  output logic       overflow,
  output logic       new_sample
);

  localparam logic [27:0] PRESC_LAST = 28'(TICK_DIV - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync_prev;
  logic [1:0]  r_settle;
  logic [27:0] r_presc;
  logic [27:0] w_presc_nx;
  logic [7:0]  r_count;
  logic [7:0]  w_count_nx;
  logic        r_overrun;
  logic        w_overrun_nx;
  logic [7:0]  r_count_bcd;
  logic [7:0]  w_count_bcd_nx;
  logic        r_valid;
  logic        w_valid_nx;
  logic        r_overflow;
  logic        w_overflow_nx;
  logic        r_new_sample;
  logic        w_new_sample_nx;
  logic        w_edge;
  logic        w_tick;

  // BCD increment; the tens digit wraps rather than leaving the legal 0-9 range
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] res;
    if (v[3:0] >= 4'd9) begin
      res[3:0] = 4'd0;
      res[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      res[3:0] = v[3:0] + 4'd1;
      res[7:4] = v[7:4];
    end
    return res;
  endfunction

  // Two-flop synchronizer, previous-value flop for edge detect, and a settle
  // counter that keeps the edge detector blind until the history flop holds a
  // real post-reset sample (so a pin held high through reset is not an edge)
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_settle    <= 2'd0;
    end else begin
      r_sync1     <= pulse_in;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      if (r_settle != 2'd3) begin
        r_settle <= r_settle + 2'd1;
      end
    end
  end

  assign w_edge = r_sync2 & ~r_sync_prev & (r_settle == 2'd3);
  assign w_tick = (r_state == ST_MEASURE) && (r_presc == PRESC_LAST);

  // State, counters and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_presc      <= 28'd0;
      r_count      <= 8'h00;
      r_overrun    <= 1'b0;
      r_count_bcd  <= 8'h00;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
      r_new_sample <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_presc      <= w_presc_nx;
      r_count      <= w_count_nx;
      r_overrun    <= w_overrun_nx;
      r_count_bcd  <= w_count_bcd_nx;
      r_valid      <= w_valid_nx;
      r_overflow   <= w_overflow_nx;
      r_new_sample <= w_new_sample_nx;
    end
  end

  // Next-state and datapath: clear beats edge, edge beats tick. The edge
  // cycle itself is prescaler count 0 of the new interval, so the restarted
  // prescaler holds 1 in the following cycle; an interval of N*TICK_DIV
  // cycles then reports exactly N ticks.
  always_comb begin
    w_state_nx      = r_state;
    w_presc_nx      = r_presc;
    w_count_nx      = r_count;
    w_overrun_nx    = r_overrun;
    w_count_bcd_nx  = r_count_bcd;
    w_valid_nx      = r_valid;
    w_overflow_nx   = r_overflow;
    w_new_sample_nx = 1'b0;
    if (clear) begin
      w_state_nx     = ST_IDLE;
      w_presc_nx     = 28'd0;
      w_count_nx     = 8'h00;
      w_overrun_nx   = 1'b0;
      w_count_bcd_nx = 8'h00;
      w_valid_nx     = 1'b0;
      w_overflow_nx  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_presc_nx   = 28'd0;
          w_count_nx   = 8'h00;
          w_overrun_nx = 1'b0;
          if (w_edge) begin
            w_state_nx = ST_MEASURE;
            w_presc_nx = 28'd1;
          end
        end
        ST_MEASURE: begin
          if (w_edge) begin
            w_count_bcd_nx  = r_count;
            w_valid_nx      = 1'b1;
            w_overflow_nx   = r_overrun;
            w_new_sample_nx = 1'b1;
            w_presc_nx      = 28'd1;
            w_count_nx      = 8'h00;
            w_overrun_nx    = 1'b0;
          end else if (w_tick) begin
            w_presc_nx = 28'd0;
            if (r_count == MAX_BCD) begin
              w_overrun_nx = 1'b1;
            end else begin
              w_count_nx = bcd_inc(r_count);
            end
          end else begin
            w_presc_nx = r_presc + 28'd1;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  assign count_bcd  = r_count_bcd;
  assign valid      = r_valid;
  assign overflow   = r_overflow;
  assign new_sample = r_new_sample;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// tb/tb_pulse_interval_meter.sv - directed self-checking bench for pulse_interval_meter
module tb_pulse_interval_meter;

  logic       clk = 1'b0;
  logic       reset;
  logic       pulse_in;
  logic       clear;
  logic [7:0] count_bcd;
  logic       valid;
  logic       overflow;
  logic       new_sample;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] tr;
  logic [7:0] c;
  logic       v;
  logic       o;

  always #5 clk = ~clk;

  pulse_interval_meter #(
    .TICK_DIV(4),
    .MAX_BCD (8'h99)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .pulse_in  (pulse_in),
    .clear     (clear),
    .count_bcd (count_bcd),
    .valid     (valid),
    .overflow  (overflow),
    .new_sample(new_sample)
  );

  // Rising edge at the next negedge, high for two samples; the next call's
  // edge lands exactly gap cycles later. Captures new_sample on the four
  // following negedges and the outputs on the third (where an update shows).
  task automatic drive_edge(input int gap, output logic [3:0] ns_tr,
                            output logic [7:0] cnt, output logic vo, output logic ovf);
    @(negedge clk); pulse_in = 1'b1;
    @(negedge clk); ns_tr[0] = new_sample;
    @(negedge clk); ns_tr[1] = new_sample; pulse_in = 1'b0;
    @(negedge clk); ns_tr[2] = new_sample; cnt = count_bcd; vo = valid; ovf = overflow;
    @(negedge clk); ns_tr[3] = new_sample;
    for (int i = 0; i < gap - 5; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pulse_in = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({count_bcd, valid, overflow, new_sample} !== 11'd0) begin
      n_bad++; $display("FAIL reset_outputs got %h/%b/%b/%b want 00/0/0/0", count_bcd, valid, overflow, new_sample);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({count_bcd, valid, overflow, new_sample} !== 11'd0) begin
      n_bad++; $display("FAIL post_reset_outputs got %h/%b/%b/%b want 00/0/0/0", count_bcd, valid, overflow, new_sample);
    end
  endtask

  task automatic test_basic();
    drive_edge(20, tr, c, v, o);
    n_cmp++; if (tr !== 4'b0000) begin n_bad++; $display("FAIL first_edge_ns got %b want 0000", tr); end
    n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL first_edge_valid got %b want 0", v); end
    drive_edge(48, tr, c, v, o);
    n_cmp++; if (tr !== 4'b0100) begin n_bad++; $display("FAIL i20_ns got %b want 0100", tr); end
    n_cmp++; if (c !== 8'h05) begin n_bad++; $display("FAIL i20_count got %h want 05", c); end
    n_cmp++; if ({v, o} !== 2'b10) begin n_bad++; $display("FAIL i20_valid_ovf got %b%b want 10", v, o); end
    drive_edge(8, tr, c, v, o);
    n_cmp++; if (tr !== 4'b0100) begin n_bad++; $display("FAIL i48_ns got %b want 0100", tr); end
    n_cmp++; if (c !== 8'h12) begin n_bad++; $display("FAIL i48_count got %h want 12", c); end
    drive_edge(500, tr, c, v, o);
    n_cmp++; if (c !== 8'h02) begin n_bad++; $display("FAIL i8_count got %h want 02", c); end
  endtask

  task automatic test_overflow();
    drive_edge(12, tr, c, v, o);
    n_cmp++; if (tr !== 4'b0100) begin n_bad++; $display("FAIL i500_ns got %b want 0100", tr); end
    n_cmp++; if (c !== 8'h99) begin n_bad++; $display("FAIL i500_count got %h want 99", c); end
    n_cmp++; if (o !== 1'b1) begin n_bad++; $display("FAIL i500_ovf got %b want 1", o); end
    drive_edge(7, tr, c, v, o);
    n_cmp++; if (c !== 8'h03) begin n_bad++; $display("FAIL i12_count got %h want 03", c); end
    n_cmp++; if (o !== 1'b0) begin n_bad++; $display("FAIL i12_ovf got %b want 0", o); end
  endtask

  task automatic test_edge_on_tick();
    drive_edge(8, tr, c, v, o);
    n_cmp++; if (c !== 8'h01) begin n_bad++; $display("FAIL tick_edge_count got %h want 01", c); end
    drive_edge(10, tr, c, v, o);
    n_cmp++; if (c !== 8'h02) begin n_bad++; $display("FAIL after_tick_edge_count got %h want 02", c); end
  endtask

  task automatic test_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    n_cmp++;
    if ({count_bcd, valid, overflow, new_sample} !== 11'd0) begin
      n_bad++; $display("FAIL clear_outputs got %h/%b/%b/%b want 00/0/0/0", count_bcd, valid, overflow, new_sample);
    end
    repeat (2) @(negedge clk);
    drive_edge(16, tr, c, v, o);
    n_cmp++; if ({tr, v} !== 5'b00000) begin n_bad++; $display("FAIL clear_first_edge got %b/%b want 0000/0", tr, v); end
    drive_edge(10, tr, c, v, o);
    n_cmp++; if (tr !== 4'b0100) begin n_bad++; $display("FAIL clear_i16_ns got %b want 0100", tr); end
    n_cmp++; if ({c, v, o} !== {8'h04, 2'b10}) begin n_bad++; $display("FAIL clear_i16_out got %h/%b/%b want 04/1/0", c, v, o); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ns;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    @(negedge clk); pulse_in = 1'b1;
    @(negedge clk); ns[1] = new_sample; pulse_in = 1'b0;
    @(negedge clk); ns[2] = new_sample; pulse_in = 1'b1;
    @(negedge clk); ns[3] = new_sample; pulse_in = 1'b0;
    @(negedge clk); ns[4] = new_sample;
    @(negedge clk); ns[5] = new_sample; c = count_bcd; v = valid; o = overflow;
    @(negedge clk); ns[6] = new_sample;
    ns[0] = 1'b0;
    n_cmp++; if (ns !== 7'b0100000) begin n_bad++; $display("FAIL b2b_ns got %b want 0100000", ns); end
    n_cmp++; if ({c, v, o} !== {8'h00, 2'b10}) begin n_bad++; $display("FAIL b2b_out got %h/%b/%b want 00/1/0", c, v, o); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    drive_edge(10, tr, c, v, o);
    n_cmp++; if (tr !== 4'b0000) begin n_bad++; $display("FAIL rmid_first_edge_ns got %b want 0000", tr); end
    @(negedge clk); reset = 1'b1; pulse_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({count_bcd, valid, overflow, new_sample} !== 11'd0) begin
        n_bad++; $display("FAIL rmid_held_high[%0d] got %h/%b/%b/%b want 00/0/0/0", i, count_bcd, valid, overflow, new_sample);
      end
    end
    pulse_in = 1'b0;
    repeat (2) @(negedge clk);
    drive_edge(20, tr, c, v, o);
    n_cmp++; if ({tr, v} !== 5'b00000) begin n_bad++; $display("FAIL rmid_fresh1 got %b/%b want 0000/0", tr, v); end
    drive_edge(8, tr, c, v, o);
    n_cmp++; if (tr !== 4'b0100) begin n_bad++; $display("FAIL rmid_fresh2_ns got %b want 0100", tr); end
    n_cmp++; if ({c, v, o} !== {8'h05, 2'b10}) begin n_bad++; $display("FAIL rmid_fresh2_out got %h/%b/%b want 05/1/0", c, v, o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_edge_on_tick();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
